// File: rtl/adder_pkg.sv
// Shared definitions for the multi-byte add/subtract sequencer.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned NBYTES_DEF = 4;

endpackage

// File: rtl/eight_bit_full_adder.sv
// 8-bit ripple-carry adder; exposes carry out of bit 7 and bit 6 for
// signed-overflow detection downstream.
module eight_bit_full_adder (
   input  logic [7:0] i0,
   input  logic [7:0] i1,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       carry,
   output logic       last_carry
);

   logic [8:0] w_c;

   // Bit-serial ripple through eight full adders
   always_comb begin
      w_c    = '0;
      sum    = '0;
      w_c[0] = cin;
      for (int unsigned i = 0; i < 8; i++) begin
         sum[i]   = i0[i] ^ i1[i] ^ w_c[i];
         w_c[i+1] = (i0[i] & i1[i]) | (w_c[i] & (i0[i] ^ i1[i]));
      end
   end

   assign carry      = w_c[8];
   assign last_carry = w_c[7];

endmodule

// File: rtl/multi_byte_adder_seq.sv
// Sequences a W-bit add/subtract through an external 8-bit adder, one byte
// per clock, LSB first, and collects the sum with carry-out and overflow.
module multi_byte_adder_seq
   import adder_pkg::*;
#(
   parameter int unsigned NBYTES = NBYTES_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       sub,
   input  logic [BYTE_W*NBYTES-1:0]   op_a,
   input  logic [BYTE_W*NBYTES-1:0]   op_b,
   output logic                       busy,
   output logic                       done,
   output logic [BYTE_W*NBYTES-1:0]   result,
   output logic                       cout,
   output logic                       ovf,
   output logic [BYTE_W-1:0]          adder_i0,
   output logic [BYTE_W-1:0]          adder_i1,
   output logic                       adder_cin,
   input  logic [BYTE_W-1:0]          adder_sum,
   input  logic                       adder_carry,
   input  logic                       adder_last_carry
);

   localparam int unsigned W    = BYTE_W * NBYTES;
   localparam int unsigned IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [W-1:0]      r_a;
   logic [W-1:0]      r_b;
   logic              r_sub;
   logic [IDXW-1:0]   r_idx;
   logic              r_carry;
   logic [W-1:0]      r_result;
   logic              r_cout;
   logic              r_ovf;
   logic              w_accept;
   logic              w_last_byte;

   assign w_last_byte = (r_idx == IDXW'(NBYTES - 1));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and status outputs
   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            done = (r_state == DONE);
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = ADD;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         ADD: begin
            busy = 1'b1;
            if (w_last_byte) begin
               w_state_nxt = DONE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Adder operand drive: current byte while adding, zero otherwise
   always_comb begin
      adder_i0  = '0;
      adder_i1  = '0;
      adder_cin = 1'b0;
      if (r_state == ADD) begin
         for (int unsigned i = 0; i < NBYTES; i++) begin
            if (r_idx == IDXW'(i)) begin
               adder_i0 = r_a[i*BYTE_W +: BYTE_W];
               adder_i1 = r_sub ? ~r_b[i*BYTE_W +: BYTE_W] : r_b[i*BYTE_W +: BYTE_W];
            end
         end
         adder_cin = r_carry;
      end
   end

   // Operand latch and per-byte result collection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_sub    <= 1'b0;
         r_idx    <= '0;
         r_carry  <= 1'b0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
      end else if (w_accept) begin
         r_a      <= op_a;
         r_b      <= op_b;
         r_sub    <= sub;
         r_idx    <= '0;
         r_carry  <= sub;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
      end else if (r_state == ADD) begin
         for (int unsigned i = 0; i < NBYTES; i++) begin
            if (r_idx == IDXW'(i)) begin
               r_result[i*BYTE_W +: BYTE_W] <= adder_sum;
            end
         end
         r_carry <= adder_carry;
         r_idx   <= r_idx + 1'b1;
         if (w_last_byte) begin
            r_cout <= adder_carry;
            r_ovf  <= adder_carry ^ adder_last_carry;
         end
      end
   end

   assign result = r_result;
   assign cout   = r_cout;
   assign ovf    = r_ovf;

endmodule

// File: tb/tb_multi_byte_adder_seq.sv
// Self-checking bench: sequencer wired to the 8-bit adder, checked against
// a plain-arithmetic reference model.
module tb_multi_byte_adder_seq;

   localparam int unsigned NB = 4;
   localparam int unsigned W  = 8 * NB;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          sub = 1'b0;
   logic [W-1:0]  op_a = '0;
   logic [W-1:0]  op_b = '0;
   logic          busy, done, cout, ovf;
   logic [W-1:0]  result;
   logic [7:0]    adder_i0, adder_i1, adder_sum;
   logic          adder_cin, adder_carry, adder_last_carry;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   multi_byte_adder_seq #(.NBYTES(NB)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub),
      .op_a(op_a), .op_b(op_b),
      .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf),
      .adder_i0(adder_i0), .adder_i1(adder_i1), .adder_cin(adder_cin),
      .adder_sum(adder_sum), .adder_carry(adder_carry),
      .adder_last_carry(adder_last_carry)
   );

   eight_bit_full_adder u_adder (
      .i0(adder_i0), .i1(adder_i1), .cin(adder_cin),
      .sum(adder_sum), .carry(adder_carry), .last_carry(adder_last_carry)
   );

   // Reference: W-bit two's-complement arithmetic on wide integers
   function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
      longint ua, ub, sa, sb, ur, sr;
      logic [W-1:0] res;
      logic c, o;
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      if (s) begin
         ur = ua - ub;
         sr = sa - sb;
         c  = (ua >= ub);
      end else begin
         ur = ua + ub;
         sr = sa + sb;
         c  = (ur >= (64'sd1 <<< W));
      end
      res = ur[W-1:0];
      o   = (sr > ((64'sd1 <<< (W-1)) - 1)) || (sr < -(64'sd1 <<< (W-1)));
      return {o, c, res};
   endfunction

   // Drives one operation, scrambles operands after acceptance, and
   // returns the cycle count to done plus per-cycle traces.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output int lat, output logic [15:0] cin_tr,
                         output logic [15:0] busy_tr, output logic [7:0] i0_c1,
                         output logic [7:0] i1_c1);
      @(negedge clk);
      start = 1'b1; op_a = a; op_b = b; sub = s;
      @(posedge clk);
      #1;
      start = 1'b0; op_a = $urandom; op_b = $urandom; sub = 1'($urandom);
      lat = 0; cin_tr = '0; busy_tr = '0; i0_c1 = '0; i1_c1 = '0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            i0_c1 = adder_i0;
            i1_c1 = adder_i1;
         end
         if (lat <= 16) begin
            cin_tr[lat-1]  = adder_cin;
            busy_tr[lat-1] = busy;
         end
         if (done) break;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      start = 1'b1; op_a = 32'hDEADBEEF; op_b = 32'h12345678;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({busy, done, result, cout, ovf, adder_i0, adder_i1, adder_cin} !== '0) begin
         n_err++;
         $display("FAIL reset: busy=%b done=%b result=%h cout=%b ovf=%b i0=%h i1=%h cin=%b (want all 0)",
                  busy, done, result, cout, ovf, adder_i0, adder_i1, adder_cin);
      end
      start = 1'b0;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed;
      logic [W-1:0] ta [6] = '{32'h000000FF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd7, 32'h80000000};
      logic [W-1:0] tb [6] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'd7, 32'd5, 32'h00000001};
      logic         ts [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [W-1:0] tr [6] = '{32'h00000100, 32'h80000000, 32'h00000000, 32'hFFFFFFFE, 32'h00000002, 32'h7FFFFFFF};
      logic         tc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic         tv [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      int lat;
      logic [15:0] cin_tr, busy_tr;
      logic [7:0] i0_c1, i1_c1, exp_i1;
      for (int i = 0; i < 6; i++) begin
         run_op(ta[i], tb[i], ts[i], lat, cin_tr, busy_tr, i0_c1, i1_c1);
         n_vec++;
         if (lat !== NB + 1) begin
            n_err++;
            $display("FAIL dir%0d latency: got %0d want %0d", i, lat, NB + 1);
         end
         n_vec++;
         if ({result, cout, ovf} !== {tr[i], tc[i], tv[i]}) begin
            n_err++;
            $display("FAIL dir%0d result: got %h c=%b v=%b want %h c=%b v=%b",
                     i, result, cout, ovf, tr[i], tc[i], tv[i]);
         end
         n_vec++;
         if (busy_tr[4:0] !== 5'b01111) begin
            n_err++;
            $display("FAIL dir%0d busy trace: got %b want 01111", i, busy_tr[4:0]);
         end
         exp_i1 = ts[i] ? ~tb[i][7:0] : tb[i][7:0];
         n_vec++;
         if ({i0_c1, i1_c1, cin_tr[0]} !== {ta[i][7:0], exp_i1, ts[i]}) begin
            n_err++;
            $display("FAIL dir%0d byte0 drive: got i0=%h i1=%h cin=%b want i0=%h i1=%h cin=%b",
                     i, i0_c1, i1_c1, cin_tr[0], ta[i][7:0], exp_i1, ts[i]);
         end
         if (i == 0) begin
            n_vec++;
            if (cin_tr[1] !== 1'b1) begin
               n_err++;
               $display("FAIL dir0 byte1 carry-in: got %b want 1", cin_tr[1]);
            end
         end
         @(negedge clk);
         n_vec++;
         if (done !== 1'b0 || busy !== 1'b0 || result !== tr[i]) begin
            n_err++;
            $display("FAIL dir%0d post-done: done=%b busy=%b result=%h want 0 0 %h",
                     i, done, busy, result, tr[i]);
         end
      end
   endtask

   task automatic test_random;
      logic [W-1:0] a, b;
      logic s;
      logic [W+1:0] exp;
      int lat;
      logic [15:0] cin_tr, busy_tr;
      logic [7:0] i0_c1, i1_c1;
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         b = $urandom;
         if (i % 8 == 0) b = a;
         s = 1'($urandom);
         exp = model(a, b, s);
         run_op(a, b, s, lat, cin_tr, busy_tr, i0_c1, i1_c1);
         n_vec++;
         if (lat !== NB + 1 || {ovf, cout, result} !== exp) begin
            n_err++;
            $display("FAIL rand%0d %h %s %h: lat=%0d got v=%b c=%b %h want lat=%0d v=%b c=%b %h",
                     i, a, s ? "-" : "+", b, lat, ovf, cout, result,
                     NB + 1, exp[W+1], exp[W], exp[W-1:0]);
         end
         repeat (2) @(negedge clk);
         n_vec++;
         if (result !== exp[W-1:0]) begin
            n_err++;
            $display("FAIL rand%0d hold: got %h want %h", i, result, exp[W-1:0]);
         end
      end
   endtask

   task automatic test_start_while_busy;
      logic [W+1:0] exp;
      int lat;
      exp = model(32'h12345678, 32'h0FEDCBA9, 1'b0);
      @(negedge clk);
      start = 1'b1; op_a = 32'h12345678; op_b = 32'h0FEDCBA9; sub = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (lat == 3) begin
            start = 1'b1; op_a = 32'hAAAAAAAA; op_b = 32'h55555555; sub = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done) break;
      end
      start = 1'b0;
      n_vec++;
      if (lat !== NB + 1 || {ovf, cout, result} !== exp) begin
         n_err++;
         $display("FAIL busy-start: lat=%0d got v=%b c=%b %h want lat=%0d v=%b c=%b %h",
                  lat, ovf, cout, result, NB + 1, exp[W+1], exp[W], exp[W-1:0]);
      end
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_err++;
         $display("FAIL busy-start idle: busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_back_to_back;
      logic [W+1:0] e1, e2;
      int lat;
      logic [15:0] cin_tr, busy_tr;
      logic [7:0] i0_c1, i1_c1;
      e1 = model(32'h01020304, 32'h10203040, 1'b0);
      e2 = model(32'h00000010, 32'h00000020, 1'b1);
      run_op(32'h01020304, 32'h10203040, 1'b0, lat, cin_tr, busy_tr, i0_c1, i1_c1);
      n_vec++;
      if (done !== 1'b1 || {ovf, cout, result} !== e1) begin
         n_err++;
         $display("FAIL b2b first: done=%b v=%b c=%b %h want 1 v=%b c=%b %h",
                  done, ovf, cout, result, e1[W+1], e1[W], e1[W-1:0]);
      end
      start = 1'b1; op_a = 32'h00000010; op_b = 32'h00000020; sub = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (done) break;
      end
      n_vec++;
      if (lat !== NB + 1 || {ovf, cout, result} !== e2) begin
         n_err++;
         $display("FAIL b2b second: lat=%0d got v=%b c=%b %h want lat=%0d v=%b c=%b %h",
                  lat, ovf, cout, result, NB + 1, e2[W+1], e2[W], e2[W-1:0]);
      end
   endtask

   task automatic test_reset_mid_op;
      int seen_done;
      @(negedge clk);
      start = 1'b1; op_a = 32'hCAFEF00D; op_b = 32'h01010101; sub = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_vec++;
      if ({busy, done, result, cout, ovf, adder_i0, adder_i1, adder_cin} !== '0) begin
         n_err++;
         $display("FAIL mid-reset: busy=%b done=%b result=%h cout=%b ovf=%b i0=%h i1=%h cin=%b (want all 0)",
                  busy, done, result, cout, ovf, adder_i0, adder_i1, adder_cin);
      end
      @(negedge clk);
      rst = 1'b0;
      seen_done = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done || busy) seen_done++;
      end
      n_vec++;
      if (seen_done !== 0 || result !== '0) begin
         n_err++;
         $display("FAIL mid-reset aftermath: active cycles=%0d result=%h want 0 0", seen_done, result);
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_random;
      test_start_while_busy;
      test_back_to_back;
      test_reset_mid_op;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
